// File: rtl/deconvolution.sv
// Recovers A from Y = A*B: a multiply-accumulate recursion followed by a 48-cycle restoring divide by B[0].
// Define DECONV_REM_CHECK_EN to also consume the N-1 tail samples and flag a nonzero residue on rem_err.
module deconvolution #(
  parameter int M = 6,
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 b_we,
  input  logic [$clog2(N)-1:0] b_addr,
  input  logic signed [15:0]   b_wdata,
  input  logic                 start,
  input  logic                 y_valid,
  output logic                 y_ready,
  input  logic signed [31:0]   y_data,
  output logic                 a_valid,
  input  logic                 a_ready,
  output logic signed [15:0]   a_data,
  output logic                 busy,
  output logic                 done,
  output logic                 div_err,
  output logic                 sat,
  output logic                 rem_err
);
  localparam int AW = $clog2(N);
  localparam int IW = $clog2(M + N) + 1;
  localparam logic [AW-1:0] K_ONE   = AW'(1);
  localparam logic [AW-1:0] K_LAST  = AW'(N - 1);
  localparam logic [IW-1:0] I_ONE   = IW'(1);
  localparam logic [IW-1:0] I_M     = IW'(M);
  localparam logic [IW-1:0] I_LASTA = IW'(M - 1);
  localparam logic [IW-1:0] I_LASTY = IW'(M + N - 2);

  typedef enum logic [2:0] {IDLE, LOAD, MAC, DIV, OUT, CHECK, FIN} state_t;

  state_t             r_state, w_next;
  logic signed [15:0] r_b [0:N-1];
  logic signed [15:0] r_hist [0:N-2];
  logic signed [47:0] r_acc;
  logic [AW-1:0]      r_k;
  logic [IW-1:0]      r_idx;
  logic [47:0]        r_rem;
  logic [47:0]        r_quo;
  logic [15:0]        r_dvs;
  logic               r_neg;
  logic [5:0]         r_dcnt;
  logic signed [15:0] r_a;
  logic               r_done, r_div_err, r_sat;
`ifdef DECONV_REM_CHECK_EN
  logic               r_rem_err;
`endif

  logic signed [15:0] w_b0;
  logic               w_mac_last, w_div_last, w_rem_phase, w_sat_hit;
  logic signed [31:0] w_prod;
  logic signed [47:0] w_acc_nxt;
  logic [47:0]        w_acc_mag;
  logic [48:0]        w_shl, w_sub;
  logic [47:0]        w_rem_nxt, w_quo_nxt;
  logic signed [15:0] w_a_sat;

  // A write coinciding with start must be visible to the B[0]==0 test.
  assign w_b0        = (b_we && b_addr == '0) ? b_wdata : r_b[0];
  assign w_mac_last  = (r_k == K_LAST);
  assign w_div_last  = (r_dcnt == 6'd47);
  assign w_rem_phase = (r_idx >= I_M);

  assign w_prod    = r_b[r_k] * r_hist[r_k - K_ONE];
  assign w_acc_nxt = r_acc - {{16{w_prod[31]}}, w_prod};
  assign w_acc_mag = w_acc_nxt[47] ? -w_acc_nxt : w_acc_nxt;

  assign w_shl     = {r_rem, r_quo[47]};
  assign w_sub     = w_shl - {33'd0, r_dvs};
  assign w_rem_nxt = w_sub[48] ? w_shl[47:0] : w_sub[47:0];
  assign w_quo_nxt = {r_quo[46:0], ~w_sub[48]};

  always_comb begin
    w_sat_hit = 1'b0;
    w_a_sat   = '0;
    if (r_neg) begin
      if (w_quo_nxt > 48'd32768) begin
        w_a_sat   = 16'sh8000;
        w_sat_hit = 1'b1;
      end else begin
        w_a_sat = -$signed(w_quo_nxt[15:0]);
      end
    end else if (w_quo_nxt > 48'd32767) begin
      w_a_sat   = 16'sh7fff;
      w_sat_hit = 1'b1;
    end else begin
      w_a_sat = $signed(w_quo_nxt[15:0]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    y_ready = 1'b0;
    a_valid = 1'b0;
    busy    = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_next = (w_b0 == 16'sd0) ? FIN : LOAD;
      end
      LOAD: begin
        y_ready = 1'b1;
        if (y_valid) w_next = MAC;
      end
      MAC:  if (w_mac_last) w_next = w_rem_phase ? CHECK : DIV;
      DIV:  if (w_div_last) w_next = OUT;
      OUT: begin
        a_valid = 1'b1;
`ifdef DECONV_REM_CHECK_EN
        if (a_ready) w_next = (r_idx < I_LASTY) ? LOAD : FIN;
`else
        if (a_ready) w_next = (r_idx < I_LASTA) ? LOAD : FIN;
`endif
      end
      CHECK:   w_next = (r_idx < I_LASTY) ? LOAD : FIN;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++)     r_b[i]    <= '0;
      for (int i = 0; i < N - 1; i++) r_hist[i] <= '0;
      r_acc     <= '0;
      r_k       <= '0;
      r_idx     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvs     <= '0;
      r_neg     <= 1'b0;
      r_dcnt    <= '0;
      r_a       <= '0;
      r_done    <= 1'b0;
      r_div_err <= 1'b0;
      r_sat     <= 1'b0;
`ifdef DECONV_REM_CHECK_EN
      r_rem_err <= 1'b0;
`endif
    end else begin
      r_done <= (r_state == FIN);
      case (r_state)
        IDLE: begin
          if (b_we) r_b[b_addr] <= b_wdata;
          if (start) begin
            for (int i = 0; i < N - 1; i++) r_hist[i] <= '0;
            r_idx     <= '0;
            r_sat     <= 1'b0;
            r_div_err <= (w_b0 == 16'sd0);
`ifdef DECONV_REM_CHECK_EN
            r_rem_err <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (y_valid) begin
            r_acc <= {{16{y_data[31]}}, y_data};
            r_k   <= K_ONE;
          end
        end
        MAC: begin
          r_acc <= w_acc_nxt;
          r_k   <= r_k + K_ONE;
          if (w_mac_last) begin
            r_rem  <= '0;
            r_quo  <= w_acc_mag;
            r_dvs  <= r_b[0][15] ? -r_b[0] : r_b[0];
            r_neg  <= w_acc_nxt[47] ^ r_b[0][15];
            r_dcnt <= '0;
          end
        end
        DIV: begin
          r_rem  <= w_rem_nxt;
          r_quo  <= w_quo_nxt;
          r_dcnt <= r_dcnt + 6'd1;
          if (w_div_last) begin
            r_a <= w_a_sat;
            if (w_sat_hit) r_sat <= 1'b1;
          end
        end
        OUT: begin
          if (a_ready) begin
            for (int i = N - 2; i > 0; i--) r_hist[i] <= r_hist[i-1];
            r_hist[0] <= r_a;
            r_idx     <= r_idx + I_ONE;
          end
        end
        CHECK: begin
          // Tail samples: A beyond the frame is zero, so shift zero into the history.
`ifdef DECONV_REM_CHECK_EN
          if (r_acc != '0) r_rem_err <= 1'b1;
`endif
          for (int i = N - 2; i > 0; i--) r_hist[i] <= r_hist[i-1];
          r_hist[0] <= '0;
          r_idx     <= r_idx + I_ONE;
        end
        default: ;
      endcase
    end
  end

  assign a_data  = r_a;
  assign done    = r_done;
  assign div_err = r_div_err;
  assign sat     = r_sat;
`ifdef DECONV_REM_CHECK_EN
  assign rem_err = r_rem_err;
`else
  assign rem_err = 1'b0;
`endif

endmodule

// File: tb/tb_deconvolution.sv
// Directed bench for deconvolution: table of single-frame vectors plus hand sequences for
// the recursion example, residue flag, B[0]==0, start+write, output backpressure and mid-frame reset.
module tb_deconvolution;
  localparam int M = 6;
  localparam int N = 8;
`ifdef DECONV_REM_CHECK_EN
  localparam int EXP_NY  = M + N - 1;
  localparam int EXP_REM = 1;
`else
  localparam int EXP_NY  = M;
  localparam int EXP_REM = 0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 b_we = 1'b0;
  logic [$clog2(N)-1:0] b_addr = '0;
  logic signed [15:0]   b_wdata = '0;
  logic                 start = 1'b0;
  logic                 y_valid = 1'b0;
  logic                 y_ready;
  logic signed [31:0]   y_data = '0;
  logic                 a_valid;
  logic                 a_ready = 1'b0;
  logic signed [15:0]   a_data;
  logic                 busy, done, div_err, sat, rem_err;

  always #5 clk = ~clk;

  deconvolution #(.M(M), .N(N)) dut (
    .clk(clk), .rst(rst), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .start(start), .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .busy(busy),
    .done(done), .div_err(div_err), .sat(sat), .rem_err(rem_err)
  );

  typedef struct {
    int b0; int b1; int y0; int y1; int a0; int a1; int sat;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;
  int yv [16];
  int aq [16];
  int n_a, n_y, n_done, lat, done_cyc, stable;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic wr_b(input int addr, input int val);
    b_we = 1'b1; b_addr = addr[$clog2(N)-1:0]; b_wdata = val[15:0];
    @(negedge clk);
    b_we = 1'b0;
  endtask

  task automatic set_kernel(input int b0, input int b1);
    for (int i = 0; i < N; i++) wr_b(i, (i == 0) ? b0 : (i == 1) ? b1 : 0);
  endtask

  task automatic clear_y();
    for (int i = 0; i < 16; i++) yv[i] = 0;
  endtask

  // One frame: start (optionally with a coefficient write), feed yv on demand, collect A.
  // The first A is held off for 'hold' cycles while its stability is watched.
  task automatic run_frame(input bit we, input int wa, input int wv, input int hold);
    int hs, held, hdat;
    hs = -1; held = 0; hdat = 0;
    n_a = 0; n_y = 0; n_done = 0; lat = -1; done_cyc = -1; stable = 1;
    for (int i = 0; i < 16; i++) aq[i] = 0;
    start = 1'b1; b_we = we; b_addr = wa[$clog2(N)-1:0]; b_wdata = wv[15:0];
    for (int cyc = 0; cyc < 3000 && n_done == 0; cyc++) begin
      @(negedge clk);
      start = 1'b0; b_we = 1'b0;
      y_valid = 1'b1;
      y_data  = (n_y < 16) ? yv[n_y] : 0;
      if (y_ready) begin
        if (hs < 0) hs = cyc;
        n_y++;
      end
      a_ready = 1'b1;
      if (a_valid) begin
        if (lat < 0) begin
          lat  = cyc - hs;
          hdat = int'(a_data);
        end
        if (held < hold) begin
          a_ready = 1'b0;
          if (int'(a_data) != hdat) stable = 0;
          held++;
        end else begin
          if (n_a < 16) aq[n_a] = int'(a_data);
          n_a++;
        end
      end else if (held > 0 && held < hold) begin
        stable = 0;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
    y_valid = 1'b0; a_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) n_done++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [10];
    int   cnt;
    tbl[0] = '{2,  0,  -7,     0,  -3,     0,     0};
    tbl[1] = '{2,  0,  -6,     0,  -3,     0,     0};
    tbl[2] = '{1,  0,  40000,  0,  32767,  0,     1};
    tbl[3] = '{1,  0,  -40000, 0,  -32768, 0,     1};
    tbl[4] = '{-3, 0,  10,     0,  -3,     0,     0};
    tbl[5] = '{3,  2,  9,      -1, 3,      -2,    0};
    tbl[6] = '{-1, 0,  -32768, 0,  32767,  0,     1};
    tbl[7] = '{1,  0,  -32768, 0,  -32768, 0,     0};
    tbl[8] = '{1,  -1, 32767,  0,  32767,  32767, 0};
    tbl[9] = '{7,  0,  100,    -100, 14,   -14,   0};

    #2 rst = 1'b0;
    #1 chk("reset_outputs", {y_ready, a_valid, busy, done, div_err, sat, rem_err, a_data}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      set_kernel(tbl[i].b0, tbl[i].b1);
      clear_y();
      yv[0] = tbl[i].y0;
      yv[1] = tbl[i].y1;
      run_frame(1'b0, 0, 0, 0);
      chk($sformatf("row%0d_a0", i), aq[0], tbl[i].a0);
      chk($sformatf("row%0d_a1", i), aq[1], tbl[i].a1);
      chk($sformatf("row%0d_sat", i), sat, tbl[i].sat);
    end

    // B = [1,1,0...]: A[n] = Y[n] - A[n-1]
    set_kernel(1, 1);
    clear_y();
    yv[0] = 1; yv[1] = 3; yv[2] = 5; yv[3] = 7; yv[4] = 9; yv[5] = 11; yv[6] = 6;
    run_frame(1'b0, 0, 0, 0);
    for (int i = 0; i < M; i++) chk($sformatf("seq_a%0d", i), aq[i], i + 1);
    chk("seq_n_a", n_a, M);
    chk("seq_n_y", n_y, EXP_NY);
    chk("seq_done_count", n_done, 1);
    chk("seq_rem_err", rem_err, 0);
    chk("seq_sat", sat, 0);
    chk("seq_latency", lat, N + 48);

    yv[6] = 7;
    run_frame(1'b0, 0, 0, 0);
    chk("resid_a5", aq[5], 6);
    chk("resid_rem_err", rem_err, EXP_REM);
    chk("resid_done_count", n_done, 1);

    // B[0]==0: start goes straight to FIN, done two cycles after start
    set_kernel(0, 5);
    clear_y();
    yv[0] = 8;
    run_frame(1'b0, 0, 0, 0);
    chk("b0zero_div_err", div_err, 1);
    chk("b0zero_n_y", n_y, 0);
    chk("b0zero_done_cyc", done_cyc, 1);
    chk("b0zero_n_a", n_a, 0);

    // start with a simultaneous B[0]=2 write; B[1]=5 remains
    run_frame(1'b1, 0, 2, 0);
    chk("startwe_div_err", div_err, 0);
    chk("startwe_a0", aq[0], 4);
    chk("startwe_a1", aq[1], -10);
    chk("startwe_a3", aq[3], -62);

    // a_ready held low for 10 cycles on the first output
    set_kernel(1, 0);
    clear_y();
    yv[0] = 123;
    run_frame(1'b0, 0, 0, 10);
    chk("bp_stable", stable, 1);
    chk("bp_a0", aq[0], 123);
    chk("bp_n_a", n_a, M);

    // reset asserted in the middle of DIV
    clear_y();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; y_valid = 1'b1; y_data = 5;
    cnt = 0;
    while (!y_ready && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    chk("mid_load_seen", y_ready, 1);
    repeat (20) @(negedge clk);
    y_valid = 1'b0;
    chk("mid_busy_before", busy, 1);
    #2 rst = 1'b0;
    #1 chk("mid_reset_outputs", {y_ready, a_valid, busy, done, div_err, sat, rem_err, a_data}, 0);
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    chk("post_reset_idle_no_done", cnt, 0);
    run_frame(1'b0, 0, 0, 0);
    chk("post_reset_b_cleared", div_err, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/deconvolution.md
DECONVOLUTION -- requirements
Module: deconvolution

Interface
REQ-001 SHALL have parameter M, default 6, meaning output sequence length (A samples per frame).
REQ-002 SHALL have parameter N, default 8, meaning kernel length (B coefficients).
REQ-003 SHALL have one clock; reset is asynchronous and active-low: clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have b_we  input  1  coefficient write strobe; b_addr  input  $clog2(N)  coefficient index; b_wdata  input  16  signed coefficient value.
REQ-006 SHALL have start  input  1  single-cycle frame start request.
REQ-007 SHALL have y_valid  input  1, y_ready  output  1, y_data  input  32 signed: convolved-sample input stream.
REQ-008 SHALL have a_valid  output  1, a_ready  input  1, a_data  output  16 signed: recovered-sample output stream.
REQ-009 SHALL have busy  output  1, done  output  1 (one-cycle pulse), div_err  output  1, sat  output  1, rem_err  output  1.

Function
REQ-010 SHALL recover A from Y = A*B by recursion: r[n] = Y[n] - sum over k=1..N-1 of B[k]*A[n-k], using A[j]=0 for j<0; A[n] = r[n]/B[0].
REQ-011 SHALL hold r and the accumulator as 48-bit signed; products 16x16 SHALL be sign-extended before accumulation.
REQ-012 SHALL divide with a 48-iteration sequential restoring divider on magnitudes, quotient truncated toward zero, sign = sign(r) XOR sign(B[0]).
REQ-013 SHALL saturate the quotient to [-32768, 32767]; any saturation SHALL set sticky sat until the next accepted start.
REQ-014 SHALL use FSM states IDLE, LOAD, MAC, DIV, OUT, CHECK, FIN.
REQ-015 IDLE: busy=0; b_we writes B[b_addr]; accepted start -> LOAD, clears history, sample index, sat, rem_err, div_err.
REQ-016 If B[0]==0 at start, SHALL set div_err, skip LOAD, go to FIN.
REQ-017 LOAD: y_ready=1; handshake (y_valid&y_ready) captures y_data -> MAC.
REQ-018 MAC: exactly N-1 cycles, one product B[k]*hist[k-1] per cycle, k=1..N-1 -> DIV (index<M) or CHECK (index>=M).
REQ-019 DIV: exactly 48 cycles -> OUT; a_valid first asserts N+48 cycles after the y handshake cycle.
REQ-020 OUT: a_valid=1, a_data stable while a_ready=0; on handshake shift A into history, index+1; -> LOAD if index<M-1, else CHECK/FIN per REQ-030.
REQ-021 CHECK: nonzero r SHALL set sticky rem_err; -> LOAD until M+N-1 samples consumed, then FIN.
REQ-022 FIN: done=1 for exactly one cycle -> IDLE.
REQ-023 busy SHALL be 1 in every state except IDLE; start and b_we SHALL be ignored while busy.
REQ-024 y_ready SHALL be 1 only in LOAD; a_valid SHALL be 1 only in OUT.
REQ-025 start and b_we asserted together in IDLE: the write SHALL complete and the frame SHALL use the new coefficient.

Reset
REQ-026 rst low SHALL asynchronously force state IDLE and all outputs to 0: y_ready, a_valid, a_data, busy, done, div_err, sat, rem_err.
REQ-027 rst low SHALL clear B[0..N-1], history, accumulator, divider registers and sample index to 0.
REQ-028 Reset mid-frame SHALL abandon the frame with no done pulse; after release the block SHALL be in IDLE.

Configuration
REQ-029 Macro DECONV_REM_CHECK_EN SHALL select remainder checking.
REQ-030 With DECONV_REM_CHECK_EN defined: a frame consumes M+N-1 Y samples; the last N-1 pass through MAC and CHECK only (no output).
REQ-031 Without it: a frame consumes M samples, OUT after the last A -> FIN, CHECK unreachable, rem_err tied to 0.

Verification
REQ-032 B=[1,1,0,0,0,0,0,0], Y=[1,3,5,7,9,11,6,0,0,0,0,0,0] -> A=[1,2,3,4,5,6], rem_err=0, sat=0, one done pulse.
REQ-033 B[0]=2, others 0, Y[0]=-7 -> A[0]=-3 (truncation toward zero); Y[0]=-6 -> A[0]=-3.
REQ-034 B[0]=1, others 0, Y[0]=40000 -> A[0]=32767, sat=1; Y[0]=-40000 -> A[0]=-32768.
REQ-035 B[0]=0, start -> div_err=1, y_ready never asserted, done 2 cycles after start.
REQ-036 Macro defined, REQ-032 data with Y[6]=7 -> A unchanged, rem_err=1 at done.
REQ-037 a_ready held low 10 cycles during OUT -> a_valid=1 and a_data constant; rst pulled low mid-DIV -> all outputs 0 immediately, no done.
